sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Shares the single asynchronous SRAM between two requesters: the CPU memory port (MAR/MDR path) and an auxiliary port used by the debug/DMA loader. It arbitrates fairly between them, sequences each access with a fixed number of wait states, and returns read data with a one-cycle acknowledge. With this block in place, the control FSM no longer hard-codes SRAM wait states. Instead, it issues a request and stalls until `cpu_ack`.

## Interface

Parameters:
- `ADDR_W`, default 20, SRAM address width.
- `DATA_W`, default 16, SRAM data width.
- `WAIT_CYCLES`, default 3, number of cycles the SRAM is held active per access. Legal values are 1–15.

Ports:
- `Clk` input 1: system clock. Everything is on its rising edge.
- `Reset_n` input 1: synchronous, active-low reset.
- `cpu_req` input 1: CPU access request, level, held until `cpu_ack`.
- `cpu_we` input 1: 1 = write, 0 = read. Valid while `cpu_req`.
- `cpu_addr` input ADDR_W: CPU address.
- `cpu_wdata` input DATA_W: CPU write data.
- `cpu_rdata` output DATA_W: CPU read data. Valid when `cpu_ack` is high on a read, and held until the next CPU read completes.
- `cpu_ack` output 1: one-cycle completion pulse for CPU.
- `aux_req`, `aux_we`, `aux_addr`, `aux_wdata`, `aux_rdata`, `aux_ack`: same as the CPU port, for the auxiliary requester.
- `sram_addr` output ADDR_W: SRAM address.
- `sram_dq_out` output DATA_W: write data toward the pad tristate.
- `sram_dq_oe` output 1: 1 = drive pads with `sram_dq_out`.
- `sram_dq_in` input DATA_W: data from the pads.
- `sram_ce_n` output 1: chip enable, active low.
- `sram_oe_n` output 1: output enable, active low.
- `sram_we_n` output 1: write enable, active low.
- `grant_aux` output 1: debug; 1 while the current or last transaction belongs to aux.

## Operation

- State machine with states IDLE, ACCESS, and DONE. All outputs are registered.
- IDLE:
  - If neither request is high, stay in IDLE.
  - If exactly one request is high, grant it.
  - If both are high, grant the port that was not granted last (round-robin). After reset, the last-granted pointer indicates aux, so the CPU wins the first contention.
  - On grant: latch we, addr, and wdata from the winner, load the wait counter with WAIT_CYCLES−1, and go to ACCESS.
- ACCESS:
  - `sram_ce_n`=0 throughout.
  - Read: `sram_oe_n`=0, `sram_we_n`=1, `sram_dq_oe`=0.
  - Write: `sram_oe_n`=1, `sram_we_n`=0, `sram_dq_oe`=1.
  - Decrement the counter each cycle. When the counter is 0, capture `sram_dq_in` (reads only) into the winner's rdata register and go to DONE.
- DONE:
  - Pulse the winner's ack for exactly one cycle.
  - `sram_ce_n`=`sram_oe_n`=`sram_we_n`=1.
  - For a write, `sram_dq_oe` stays 1 for this cycle to provide data hold.
  - Next state is IDLE.
- Requester rules:
  - A requester must deassert req in the cycle after ack, or present new fields for a back-to-back access.
  - A req still high in IDLE is treated as a new request.
  - Request fields are sampled only in IDLE. Changing them during ACCESS or DONE has no effect.
- The losing requester simply waits. It is never dropped, and its wait is bounded at one transaction (WAIT_CYCLES+2 cycles).
- Only one device drives the SRAM pads at a time: `sram_dq_oe` is 0 in IDLE and during reads.

## Timing

- Reset values: `sram_ce_n`=`sram_oe_n`=`sram_we_n`=1, `sram_dq_oe`=0, `sram_addr`=0, `sram_dq_out`=0, `cpu_ack`=`aux_ack`=0, `cpu_rdata`=`aux_rdata`=0, `grant_aux`=1, state IDLE.
- Request sampled high in IDLE at edge 0:
  - ACCESS occupies cycles 1..WAIT_CYCLES.
  - DONE (ack high, rdata valid) is cycle WAIT_CYCLES+1.
  - IDLE is cycle WAIT_CYCLES+2.
- Latency from req to ack is WAIT_CYCLES+1 cycles. Minimum spacing between acks is WAIT_CYCLES+2 cycles.
- `sram_addr` is stable from cycle 1 through DONE.
- Simultaneous requests in the same IDLE cycle are resolved by the round-robin pointer. The pointer updates on grant.
- `Reset_n` low during ACCESS or DONE:
  - At the next edge, all outputs take their reset values and no ack is issued.
  - The interrupted access is abandoned, and the requester must re-request.
- A req that drops before ack (protocol violation) does not abort the access. The ack is still issued.

## Test plan

- **Reset:** with `Reset_n`=0 for 2 cycles, all outputs equal their reset values; releasing reset with no requests leaves the block in IDLE with `sram_ce_n`=1.
- **CPU read:** with WAIT_CYCLES=3, CPU reads addr 0x00123 holding 0xBEEF. Required response: `sram_oe_n`=0 for exactly cycles 1–3, `cpu_ack`=1 only in cycle 4, `cpu_rdata`=0xBEEF, and `aux_ack` never asserted.
- **Aux write:** aux writes 0x5A5A to 0x00040. Required response: `sram_we_n`=0 for cycles 1–3, `sram_dq_oe`=1 for cycles 1–4, and a subsequent CPU read of 0x00040 returns 0x5A5A.
- **Contention:** both requests held continuously after reset. Grants alternate CPU, aux, CPU, aux, with acks spaced 5 cycles apart and `grant_aux` toggling 0, 1, 0, 1.
- **Reset mid-access:** assert `Reset_n`=0 in cycle 2 of a CPU write. Next cycle, `sram_we_n`=1 and `sram_dq_oe`=0, no `cpu_ack` is issued, and a re-request completes normally.
- **Back-to-back:** CPU holds req with a new address in the cycle after ack. The second access starts immediately from IDLE, and the two acks are WAIT_CYCLES+2 cycles apart.

Source files
------------

// File: rtl/sram_arbiter.sv
// Purpose: round-robin arbiter sharing one async SRAM between the CPU port and the aux (debug/DMA) port.
// Latency: req sampled in IDLE -> WAIT_CYCLES ACCESS cycles -> 1-cycle ack (DONE), so req-to-ack is WAIT_CYCLES+1.
// Backpressure: a requester holds req until its ack; the loser waits at most one transaction.
module sram_arbiter #(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 3
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              aux_req,
  input  logic              aux_we,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [DATA_W-1:0] aux_wdata,
  output logic [DATA_W-1:0] aux_rdata,
  output logic              aux_ack,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [DATA_W-1:0] sram_dq_in,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              grant_aux
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dq_out_q, dq_out_d;
  logic              dq_oe_q, dq_oe_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              aux_ack_q, aux_ack_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] aux_rdata_q, aux_rdata_d;
  // grant_aux doubles as the round-robin "last granted" pointer.
  logic              grant_aux_q, grant_aux_d;
  logic              pick_aux;
  logic              pick_we;

  // Next-state and next-output logic; every SRAM strobe is computed one cycle ahead so the pins come straight from flops.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    dq_out_d    = dq_out_q;
    dq_oe_d     = dq_oe_q;
    ce_n_d      = ce_n_q;
    oe_n_d      = oe_n_q;
    we_n_d      = we_n_q;
    cpu_ack_d   = 1'b0;
    aux_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    aux_rdata_d = aux_rdata_q;
    grant_aux_d = grant_aux_q;
    pick_aux    = 1'b0;
    pick_we     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cpu_req || aux_req) begin
          // Aux wins when alone, or on contention when CPU went last.
          pick_aux    = aux_req && (!cpu_req || !grant_aux_q);
          pick_we     = pick_aux ? aux_we : cpu_we;
          grant_aux_d = pick_aux;
          we_d        = pick_we;
          addr_d      = pick_aux ? aux_addr  : cpu_addr;
          dq_out_d    = pick_aux ? aux_wdata : cpu_wdata;
          cnt_d       = CNT_LOAD;
          state_d     = ST_ACCESS;
          ce_n_d      = 1'b0;
          oe_n_d      = pick_we;
          we_n_d      = !pick_we;
          dq_oe_d     = pick_we;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_DONE;
          ce_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          we_n_d  = 1'b1;
          // dq_oe keeps its write value through DONE for data hold.
          if (grant_aux_q) begin
            aux_ack_d = 1'b1;
            if (!we_q) aux_rdata_d = sram_dq_in;
          end else begin
            cpu_ack_d = 1'b1;
            if (!we_q) cpu_rdata_d = sram_dq_in;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        dq_oe_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        dq_oe_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset; reset abandons any access in flight.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      dq_out_q    <= '0;
      dq_oe_q     <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      cpu_ack_q   <= 1'b0;
      aux_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      aux_rdata_q <= '0;
      grant_aux_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      dq_out_q    <= dq_out_d;
      dq_oe_q     <= dq_oe_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      cpu_ack_q   <= cpu_ack_d;
      aux_ack_q   <= aux_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      aux_rdata_q <= aux_rdata_d;
      grant_aux_q <= grant_aux_d;
    end
  end

  assign sram_addr   = addr_q;
  assign sram_dq_out = dq_out_q;
  assign sram_dq_oe  = dq_oe_q;
  assign sram_ce_n   = ce_n_q;
  assign sram_oe_n   = oe_n_q;
  assign sram_we_n   = we_n_q;
  assign cpu_ack     = cpu_ack_q;
  assign aux_ack     = aux_ack_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign aux_rdata   = aux_rdata_q;
  assign grant_aux   = grant_aux_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a small behavioural SRAM model.
// Cycle k means the interval after the k-th rising edge following the one that sampled the request.
// Inputs change and outputs are sampled on the falling edge.
module tb_sram_arbiter;

  logic        Clk;
  logic        Reset_n;
  logic        cpu_req, cpu_we;
  logic [19:0] cpu_addr;
  logic [15:0] cpu_wdata, cpu_rdata;
  logic        cpu_ack;
  logic        aux_req, aux_we;
  logic [19:0] aux_addr;
  logic [15:0] aux_wdata, aux_rdata;
  logic        aux_ack;
  logic [19:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
  logic        grant_aux;

  int vec_cnt;
  int miscmp_cnt;

  logic [15:0] mem [0:4095];
  logic        preload_en;
  logic [11:0] preload_addr;
  logic [15:0] preload_dat;

  sram_arbiter #(.ADDR_W(20), .DATA_W(16), .WAIT_CYCLES(3)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_rdata(aux_rdata), .aux_ack(aux_ack),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .grant_aux(grant_aux)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // SRAM model: reads drive data while chip and output enables are low, writes land on the clock edge.
  assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[11:0]] : 16'h0000;

  always @(posedge Clk) begin
    if (preload_en)
      mem[preload_addr] <= preload_dat;
    else if (!sram_ce_n && !sram_we_n && sram_dq_oe)
      mem[sram_addr[11:0]] <= sram_dq_out;
  end

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    aux_req = 0; aux_we = 0; aux_addr = '0; aux_wdata = '0;
  endtask

  task automatic test_reset();
    Reset_n = 0;
    repeat (2) @(negedge Clk);
    vec_cnt++;
    if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe} !== 4'b1110) begin
      miscmp_cnt++;
      $display("FAIL reset_strobes got %b want 1110", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe});
    end
    vec_cnt++;
    if (sram_addr !== 20'h0 || sram_dq_out !== 16'h0) begin
      miscmp_cnt++;
      $display("FAIL reset_addr_data got %h/%h want 0/0", sram_addr, sram_dq_out);
    end
    vec_cnt++;
    if ({cpu_ack, aux_ack, grant_aux} !== 3'b001 || cpu_rdata !== 16'h0 || aux_rdata !== 16'h0) begin
      miscmp_cnt++;
      $display("FAIL reset_ports got ack=%b%b grant_aux=%b rdata=%h/%h want 00 1 0/0",
               cpu_ack, aux_ack, grant_aux, cpu_rdata, aux_rdata);
    end
    Reset_n = 1;
    repeat (3) @(negedge Clk);
    vec_cnt++;
    if (sram_ce_n !== 1'b1 || cpu_ack !== 1'b0 || aux_ack !== 1'b0) begin
      miscmp_cnt++;
      $display("FAIL reset_idle got ce_n=%b acks=%b%b want 1 00", sram_ce_n, cpu_ack, aux_ack);
    end
  endtask

  task automatic test_cpu_read();
    cpu_req = 1; cpu_we = 0; cpu_addr = 20'h00123;
    for (int k = 1; k <= 6; k++) begin
      @(negedge Clk);
      vec_cnt++;
      if (sram_oe_n !== ((k >= 1 && k <= 3) ? 1'b0 : 1'b1)) begin
        miscmp_cnt++;
        $display("FAIL cpu_read_oe_n cycle %0d got %b", k, sram_oe_n);
      end
      vec_cnt++;
      if (cpu_ack !== (k == 4) || aux_ack !== 1'b0) begin
        miscmp_cnt++;
        $display("FAIL cpu_read_ack cycle %0d got cpu=%b aux=%b want cpu=%b aux=0", k, cpu_ack, aux_ack, k == 4);
      end
      if (k <= 4) begin
        vec_cnt++;
        if (sram_addr !== 20'h00123 || sram_dq_oe !== 1'b0) begin
          miscmp_cnt++;
          $display("FAIL cpu_read_addr cycle %0d got %h oe=%b want 00123 oe=0", k, sram_addr, sram_dq_oe);
        end
      end
      if (k == 4) begin
        vec_cnt++;
        if (cpu_rdata !== 16'hBEEF) begin
          miscmp_cnt++;
          $display("FAIL cpu_read_data got %h want beef", cpu_rdata);
        end
        cpu_req = 0;
      end
    end
  endtask

  task automatic test_aux_write();
    int got;
    aux_req = 1; aux_we = 1; aux_addr = 20'h00040; aux_wdata = 16'h5A5A;
    for (int k = 1; k <= 6; k++) begin
      @(negedge Clk);
      vec_cnt++;
      if (sram_we_n !== ((k >= 1 && k <= 3) ? 1'b0 : 1'b1)) begin
        miscmp_cnt++;
        $display("FAIL aux_write_we_n cycle %0d got %b", k, sram_we_n);
      end
      vec_cnt++;
      if (sram_dq_oe !== ((k >= 1 && k <= 4) ? 1'b1 : 1'b0)) begin
        miscmp_cnt++;
        $display("FAIL aux_write_dq_oe cycle %0d got %b", k, sram_dq_oe);
      end
      vec_cnt++;
      if (aux_ack !== (k == 4) || cpu_ack !== 1'b0) begin
        miscmp_cnt++;
        $display("FAIL aux_write_ack cycle %0d got aux=%b cpu=%b", k, aux_ack, cpu_ack);
      end
      if (k == 4) aux_req = 0;
    end
    // Read back through the CPU port.
    got = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 20'h00040;
    for (int k = 1; k <= 10; k++) begin
      @(negedge Clk);
      if (cpu_ack && got == 0) begin
        got = k;
        cpu_req = 0;
        vec_cnt++;
        if (cpu_rdata !== 16'h5A5A) begin
          miscmp_cnt++;
          $display("FAIL aux_write_readback got %h want 5a5a", cpu_rdata);
        end
      end
    end
    vec_cnt++;
    if (got != 4) begin
      miscmp_cnt++;
      $display("FAIL readback_latency got cycle %0d want 4 (0 = no ack)", got);
    end
    cpu_req = 0;
  endtask

  task automatic test_contention();
    Reset_n = 0;
    repeat (2) @(negedge Clk);
    Reset_n = 1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 20'h00123;
    aux_req = 1; aux_we = 0; aux_addr = 20'h00040;
    for (int k = 1; k <= 20; k++) begin
      @(negedge Clk);
      vec_cnt++;
      if (cpu_ack !== (k == 4 || k == 14) || aux_ack !== (k == 9 || k == 19)) begin
        miscmp_cnt++;
        $display("FAIL contention_ack cycle %0d got cpu=%b aux=%b", k, cpu_ack, aux_ack);
      end
      vec_cnt++;
      if (grant_aux !== (((k - 1) / 5) % 2 == 1)) begin
        miscmp_cnt++;
        $display("FAIL contention_grant cycle %0d got %b want %b", k, grant_aux, ((k - 1) / 5) % 2 == 1);
      end
      if (k == 9) begin
        vec_cnt++;
        if (aux_rdata !== 16'h5A5A || cpu_rdata !== 16'hBEEF) begin
          miscmp_cnt++;
          $display("FAIL contention_data got cpu=%h aux=%h want beef 5a5a", cpu_rdata, aux_rdata);
        end
      end
      if (k == 20) begin
        cpu_req = 0;
        aux_req = 0;
      end
    end
    repeat (2) @(negedge Clk);
    vec_cnt++;
    if (sram_ce_n !== 1'b1 || grant_aux !== 1'b1) begin
      miscmp_cnt++;
      $display("FAIL contention_quiet got ce_n=%b grant_aux=%b want 1 1", sram_ce_n, grant_aux);
    end
  endtask

  task automatic test_reset_mid();
    cpu_req = 1; cpu_we = 1; cpu_addr = 20'h00077; cpu_wdata = 16'h1234;
    @(negedge Clk);
    vec_cnt++;
    if (sram_we_n !== 1'b0 || sram_dq_oe !== 1'b1) begin
      miscmp_cnt++;
      $display("FAIL reset_mid_start got we_n=%b dq_oe=%b want 0 1", sram_we_n, sram_dq_oe);
    end
    @(negedge Clk);
    Reset_n = 0;
    @(negedge Clk);
    vec_cnt++;
    if ({sram_ce_n, sram_we_n, sram_dq_oe, cpu_ack} !== 4'b1100) begin
      miscmp_cnt++;
      $display("FAIL reset_mid_abort got ce_n,we_n,dq_oe,ack=%b want 1100", {sram_ce_n, sram_we_n, sram_dq_oe, cpu_ack});
    end
    Reset_n = 1;
    // Req still high: a fresh grant at edge 3, ack in cycle 7.
    for (int k = 4; k <= 9; k++) begin
      @(negedge Clk);
      vec_cnt++;
      if (cpu_ack !== (k == 7)) begin
        miscmp_cnt++;
        $display("FAIL reset_mid_reack cycle %0d got %b want %b", k, cpu_ack, k == 7);
      end
      if (k == 7) cpu_req = 0;
    end
    vec_cnt++;
    if (mem[12'h077] !== 16'h1234) begin
      miscmp_cnt++;
      $display("FAIL reset_mid_mem got %h want 1234", mem[12'h077]);
    end
  endtask

  task automatic test_back_to_back();
    cpu_req = 1; cpu_we = 0; cpu_addr = 20'h00123;
    for (int k = 1; k <= 11; k++) begin
      @(negedge Clk);
      vec_cnt++;
      if (cpu_ack !== (k == 4 || k == 9)) begin
        miscmp_cnt++;
        $display("FAIL b2b_ack cycle %0d got %b want %b", k, cpu_ack, k == 4 || k == 9);
      end
      if (k == 4) begin
        vec_cnt++;
        if (cpu_rdata !== 16'hBEEF) begin
          miscmp_cnt++;
          $display("FAIL b2b_first_data got %h want beef", cpu_rdata);
        end
        cpu_addr = 20'h00040;
      end
      if (k == 6) begin
        vec_cnt++;
        if (sram_addr !== 20'h00040 || sram_ce_n !== 1'b0) begin
          miscmp_cnt++;
          $display("FAIL b2b_second_addr got %h ce_n=%b want 00040 0", sram_addr, sram_ce_n);
        end
      end
      if (k == 9) begin
        vec_cnt++;
        if (cpu_rdata !== 16'h5A5A) begin
          miscmp_cnt++;
          $display("FAIL b2b_second_data got %h want 5a5a", cpu_rdata);
        end
        cpu_req = 0;
      end
    end
  endtask

  initial begin
    vec_cnt = 0;
    miscmp_cnt = 0;
    Reset_n = 0;
    idle_inputs();
    preload_en = 1; preload_addr = 12'h123; preload_dat = 16'hBEEF;
    @(negedge Clk);
    preload_en = 0;
    test_reset();
    test_cpu_read();
    test_aux_write();
    test_contention();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
    $finish;
  end

endmodule
